// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux channel-scan sequencer.
// Holds the FSM state type, the default geometry and the select-width helper.
package mux_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DWELL_W = 8;

  // Width of the channel select; a single-channel scan still drives one select bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_ctr.sv
// Loadable down-counter that times the settle window on each channel.
// Load has priority; the count parks at zero until reloaded.
module mux_scan_dwell_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: reload, decrement towards zero, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Channel-scan sequencer: steps the mux select over every channel, dwells, samples
// mux_y into a snapshot word and hands it downstream over valid/ready.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  DWELL_W = DEF_DWELL_W,
  localparam int SEL_W   = sel_width(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_y,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_CH-1:0]  snap,
  output logic               snap_valid,
  input  logic               snap_ready,
  output logic               busy,
  output logic               overrun
);

  state_e             state_r;
  logic [SEL_W-1:0]   ch_r;
  logic [DWELL_W-1:0] dwell_q_r;
  logic [NUM_CH-2:0]  work_r;
  logic [NUM_CH-1:0]  snap_r;
  logic               snap_valid_r;
  logic               busy_r;
  logic               overrun_r;

  logic               go_s;
  logic               sample_s;
  logic               last_s;
  logic               cnt_en_s;
  logic               cnt_load_s;
  logic [DWELL_W-1:0] cnt_val_s;
  logic               cnt_zero_s;

  // Scan control decode: start of scan, sample edges and dwell-counter reloads
  always_comb begin
    go_s       = 1'b0;
    sample_s   = 1'b0;
    last_s     = 1'b0;
    cnt_en_s   = 1'b0;
    cnt_load_s = 1'b0;
    cnt_val_s  = dwell_q_r;
    if (ena) begin
      case (state_r)
        ST_IDLE: go_s = start | cont;
        ST_SCAN: begin
          cnt_en_s = 1'b1;
          sample_s = cnt_zero_s;
          last_s   = cnt_zero_s && (ch_r == SEL_W'(NUM_CH - 1));
        end
        default: go_s = 1'b0;
      endcase
    end else begin
      go_s = 1'b0;
    end
    // A fresh scan (including a back-to-back continuous one) picks up the live dwell
    if (go_s || (last_s && cont)) begin
      cnt_load_s = 1'b1;
      cnt_val_s  = dwell;
    end else if (sample_s && !last_s) begin
      cnt_load_s = 1'b1;
      cnt_val_s  = dwell_q_r;
    end else begin
      cnt_load_s = 1'b0;
    end
  end

  mux_scan_dwell_ctr #(
    .W(DWELL_W)
  ) u_dwell_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en_s),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Scan FSM, channel index, work bits, snapshot handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ch_r         <= '0;
      dwell_q_r    <= '0;
      work_r       <= '0;
      snap_r       <= '0;
      snap_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (snap_valid_r && snap_ready) begin
        snap_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r   <= ST_SCAN;
            busy_r    <= 1'b1;
            ch_r      <= '0;
            dwell_q_r <= dwell;
            if (start) begin
              overrun_r <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (last_s) begin
            // Last channel goes straight into the snapshot, bypassing work_r
            snap_r       <= {mux_y, work_r};
            snap_valid_r <= 1'b1;
            if (snap_valid_r && !snap_ready) begin
              overrun_r <= 1'b1;
            end
            ch_r <= '0;
            if (cont) begin
              dwell_q_r <= dwell;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (sample_s) begin
            work_r[ch_r] <= mux_y;
            ch_r         <= ch_r + SEL_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ch_r    <= '0;
        end
      endcase
    end
  end

  assign sel        = ch_r;
  assign snap       = snap_r;
  assign snap_valid = snap_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: directed scenarios plus random traffic,
// every cycle compared against a progress-based behavioural model of the scan.
module tb_mux_scan_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       cont;
  logic [7:0] dwell;
  logic       mux_y;
  logic [1:0] sel;
  logic [3:0] snap;
  logic       snap_valid;
  logic       snap_ready;
  logic       busy;
  logic       overrun;
  logic [3:0] data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a scan is a count of elapsed active cycles
  bit       m_busy;
  bit       m_valid;
  bit       m_ovr;
  bit [3:0] m_snap;
  bit [3:0] m_work;
  int       m_prog;
  int       m_d;

  always #5 clk = ~clk;

  always_comb mux_y = data[sel];

  mux_scan_seq #(
    .NUM_CH  (N),
    .DWELL_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .cont       (cont),
    .dwell      (dwell),
    .mux_y      (mux_y),
    .sel        (sel),
    .snap       (snap),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_sel();
    return m_busy ? (m_prog / (m_d + 1)) : 0;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_snap  = 4'b0;
    m_work  = 4'b0;
    m_prog  = 0;
    m_d     = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    bit old_valid;
    int ch;
    old_valid = m_valid;
    if (snap_ready && m_valid) m_valid = 1'b0;
    if (!m_busy) begin
      if (ena && (start || cont)) begin
        m_busy = 1'b1;
        m_prog = 0;
        m_d    = int'(dwell);
        if (start) m_ovr = 1'b0;
      end
    end else if (ena) begin
      ch = m_prog / (m_d + 1);
      if ((m_prog % (m_d + 1)) == m_d) begin
        m_work[ch] = data[ch];
        if (ch == N - 1) begin
          if (old_valid && !snap_ready) m_ovr = 1'b1;
          m_snap  = m_work;
          m_valid = 1'b1;
          if (cont) begin
            m_prog = 0;
            m_d    = int'(dwell);
          end else begin
            m_busy = 1'b0;
            m_prog = 0;
          end
        end else begin
          m_prog++;
        end
      end else begin
        m_prog++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel"}, {6'd0, sel}, 8'(model_sel()));
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
    check({tag, ".valid"}, {7'd0, snap_valid}, {7'd0, m_valid});
    check({tag, ".snap"}, {4'd0, snap}, {4'd0, m_snap});
    check({tag, ".ovr"}, {7'd0, overrun}, {7'd0, m_ovr});
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    dwell      = 8'd0;
    snap_ready = 1'b0;
    data       = 4'b1010;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single shot, dwell 0
    start = 1'b1;
    tick("s1");
    start = 1'b0;
    repeat (4) tick("s1");
    check("s1_snap", {4'd0, snap}, 8'h0a);
    check("s1_valid", {7'd0, snap_valid}, 8'd1);
    check("s1_busy", {7'd0, busy}, 8'd0);
    snap_ready = 1'b1;
    tick("s1_ack");
    snap_ready = 1'b0;

    // Dwell 3, dwell changed mid-scan
    dwell = 8'd3;
    start = 1'b1;
    tick("s2");
    start = 1'b0;
    repeat (5) tick("s2");
    dwell = 8'd0;
    repeat (10) tick("s2");
    check("s2_e15_valid", {7'd0, snap_valid}, 8'd0);
    tick("s2");
    check("s2_e16_valid", {7'd0, snap_valid}, 8'd1);
    check("s2_snap", {4'd0, snap}, 8'h0a);
    snap_ready = 1'b1;
    tick("s2_ack");
    snap_ready = 1'b0;

    // Continuous without consumer: overrun on second publish
    cont = 1'b1;
    tick("s3");
    repeat (4) tick("s3");
    data = 4'b0110;
    repeat (4) tick("s3");
    check("s3_snap", {4'd0, snap}, 8'h06);
    check("s3_ovr", {7'd0, overrun}, 8'd1);
    cont       = 1'b0;
    snap_ready = 1'b1;
    repeat (5) tick("s3_drain");
    // Continuous with consumer always ready
    start = 1'b1;
    cont  = 1'b1;
    tick("s3b");
    start = 1'b0;
    repeat (12) tick("s3b");
    check("s3b_ovr", {7'd0, overrun}, 8'd0);
    cont = 1'b0;
    repeat (5) tick("s3b_drain");
    snap_ready = 1'b0;

    // Dwell 1 with a 5-cycle enable stall on channel 2
    data  = 4'b1010;
    dwell = 8'd1;
    start = 1'b1;
    tick("s4");
    start = 1'b0;
    repeat (4) tick("s4");
    check("s4_sel_stall", {6'd0, sel}, 8'd2);
    ena = 1'b0;
    repeat (5) tick("s4_stall");
    ena = 1'b1;
    repeat (3) tick("s4");
    check("s4_e12_valid", {7'd0, snap_valid}, 8'd0);
    tick("s4");
    check("s4_e13_valid", {7'd0, snap_valid}, 8'd1);
    check("s4_snap", {4'd0, snap}, 8'h0a);
    snap_ready = 1'b1;
    tick("s4_ack");
    snap_ready = 1'b0;

    // Asynchronous reset in the middle of a scan
    dwell = 8'd2;
    start = 1'b1;
    tick("s5");
    start = 1'b0;
    repeat (4) tick("s5");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("s5_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick("s5_idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ena        = ($urandom_range(0, 7) != 0);
      start      = ($urandom_range(0, 7) == 0);
      snap_ready = $urandom_range(0, 1) == 1;
      dwell      = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      if ($urandom_range(0, 9) == 0) data = 4'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Channel-scan sequencer that sits directly upstream of the 4:1 select mux in the tile. It drives the mux select lines, dwells a programmable number of cycles on each channel so the mux output settles, samples the returned mux output, and assembles one bit per channel into a snapshot word. The snapshot is handed downstream over a valid/ready handshake. The block runs single-shot or continuous scans, and flags overruns when the consumer does not keep up.

## Interface
- `NUM_CH`, default 4: number of mux channels scanned; `SEL_W` = clog2(`NUM_CH`).
- `DWELL_W`, default 8: width of the dwell setting.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: scan enable; low freezes scan progress.
- `start` in 1: level-sampled request to begin a scan; honoured only in IDLE with `ena`=1.
- `cont` in 1: continuous mode; a new scan starts immediately after each one completes.
- `dwell` in `DWELL_W`: settle cycles per channel; latched at scan start.
- `mux_y` in 1: mux output returned from the mux stage.
- `sel` out `SEL_W`: channel select driven to the mux.
- `snap` out `NUM_CH`: snapshot; bit i = `mux_y` sampled while `sel`=i.
- `snap_valid` out 1: snapshot available.
- `snap_ready` in 1: consumer accepts the snapshot.
- `busy` out 1: high while in SCAN.
- `overrun` out 1: sticky; a snapshot was overwritten before it was consumed.

## Operation
- States: IDLE and SCAN.
- **IDLE**
  - `sel`=0, `busy`=0.
  - `start`=1 or `cont`=1, with `ena`=1, moves to SCAN: ch=0, cnt=`dwell`, dwell_q=`dwell`.
  - An accepted `start` also clears `overrun`.
- **SCAN**
  - `sel`=ch. While cnt≠0, cnt decrements.
  - When cnt=0: sample `mux_y` into work[ch].
    - If ch<`NUM_CH`-1: ch++, cnt=dwell_q.
    - Else publish the snapshot.
  - Each channel is held for dwell_q+1 cycles. A `dwell` of 0 is legal and gives 1 cycle per channel.
- **Publish** (last sample edge)
  - `snap` ← {`mux_y`, work[`NUM_CH`-2:0]}, `snap_valid` ← 1.
  - If `cont`=1: stay in SCAN with ch=0, cnt=`dwell` (re-latched). There is no gap cycle.
  - Else: go to IDLE.
- **Handshake**
  - `snap_valid` and `snap` hold until an edge with `snap_ready`=1 clears `snap_valid`.
  - `snap_ready` is honoured regardless of `ena`.
- **Overrun**
  - Publish while `snap_valid`=1 and `snap_ready`=0: `snap` is overwritten, `snap_valid` stays 1, `overrun` ← 1.
  - Publish with `snap_ready`=1 in the same cycle: the old snapshot is consumed, the new one is loaded, `snap_valid` stays 1, and `overrun` is unchanged.
- **`ena`=0**
  - State, ch, cnt and `sel` freeze.
  - `start` and `cont` are ignored.
  - No sampling occurs.
- **Mid-scan changes**
  - `start` during SCAN is ignored.
  - `cont` dropped mid-scan: the current scan completes, then the block returns to IDLE.
  - `dwell` changes mid-scan take effect from the next scan.
- **Reset** (any time, including mid-scan): state=IDLE, `sel`=0, `snap`=0, `snap_valid`=0, `busy`=0, `overrun`=0, ch=0, cnt=0, work=0.

## Timing
- `start` is sampled at edge E0. After E0: `busy`=1, `sel`=0.
- Channel i is sampled at edge E0+(i+1)(D+1), where D=dwell_q.
- `snap_valid` rises after edge E0+`NUM_CH`(D+1).
  - Example: D=0, 4 channels → valid after E4.
  - Example: D=3 → valid after E16.
- `sel` changes only on edges. `mux_y` is assumed settled within the dwell window; the block adds no synchroniser.
- Single-shot: `busy` falls at the same edge that `snap_valid` rises.
- Continuous, `ena`=1: one snapshot every `NUM_CH`(D+1) cycles.
- Each `ena`=0 cycle delays completion by exactly one cycle.

## Structure
- Package `mux_scan_pkg`:
  - state enum (IDLE, SCAN);
  - default `NUM_CH`/`DWELL_W` constants;
  - `SEL_W` derivation function.
- Sub-module `mux_scan_dwell_ctr`: loadable down-counter with enable and a zero flag, instanced once.
- Top level: FSM, channel index, work register, snapshot/handshake and `overrun` logic.

## Test plan
- Mux model for all scenarios: `mux_y`=data[`sel`], data=4'b1010.
- Single-shot, D=0, `start` pulse at E0 → `sel` 0,1,2,3 one cycle each; `snap`=4'b1010 with `snap_valid`=1 after E4; `busy`=0 after E4.
- D=3, single-shot → each `sel` value held 4 cycles; valid after E16; `snap`=4'b1010. Changing `dwell` to 0 mid-scan has no effect on timing.
- Continuous, D=0, `snap_ready`=0, data changed to 4'b0110 after the first publish → second publish at E8 gives `snap`=4'b0110, `overrun`=1. With `snap_ready`=1 throughout, `overrun` stays 0 and a snapshot arrives every 4 cycles.
- D=1, `ena` low for 5 cycles during channel 2 → `sel` frozen at 2 for the stall; valid after E13 instead of E8; `snap` correct.
- Assert `rst_n`=0 asynchronously mid-scan → all outputs are 0 immediately, before the next edge. After release, no `snap_valid` appears until a new `start`.
